// File: rtl/mac_accumulator_if.sv
// Handshake bus for mac_accumulator: term input channel and result output channel.
interface mac_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_overflow;

  // Producer/consumer side (drives terms, accepts results)
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_overflow
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_overflow
  );
endinterface

// File: rtl/mac_accumulator.sv
// Q2.6 signed multiply-accumulate over batches of 8 terms.
// Stage 1 registers a floored, saturated product; stage 2 adds it into a
// saturating accumulator. A sticky flag records any saturation in the batch.
module mac_accumulator (
  input  logic              clk,
  input  logic              rst,
  mac_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {ACC, FLUSH, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         count;
  logic signed [7:0]  acc;
  logic signed [7:0]  p_reg;
  logic               p_valid;
  logic               sticky;
  logic               out_valid_q;
  logic [7:0]         out_result_q;
  logic               out_ovf_q;

  logic               accept;
  logic               handshake;
  logic signed [15:0] prod;
  logic signed [15:0] prod_sh;
  logic signed [7:0]  prod_sat;
  logic               prod_ovf;
  logic signed [8:0]  sum;
  logic signed [7:0]  sum_sat;
  logic               sum_ovf;

  assign bus.in_ready     = (state_q == ACC) && !rst;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_ovf_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign handshake = out_valid_q && bus.out_ready;

  // Stage-1 combinational product: Q4.12 floored to Q2.6, then clamped
  always_comb begin
    prod     = $signed(bus.in_a) * $signed(bus.in_b);
    prod_sh  = prod >>> 6;
    prod_ovf = 1'b0;
    prod_sat = prod_sh[7:0];
    if (prod_sh > 16'sd127) begin
      prod_sat = 8'sh7F;
      prod_ovf = 1'b1;
    end else if (prod_sh < -16'sd128) begin
      prod_sat = 8'sh80;
      prod_ovf = 1'b1;
    end
  end

  // Stage-2 combinational sum with sign-based saturation
  always_comb begin
    sum     = {acc[7], acc} + {p_reg[7], p_reg};
    sum_ovf = sum[8] ^ sum[7];
    sum_sat = sum[7:0];
    if (sum_ovf) begin
      sum_sat = sum[8] ? 8'sh80 : 8'sh7F;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: ACC until the 8th accept, one FLUSH cycle, DONE until handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && (count == 3'd7)) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (handshake) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Datapath: product pipeline, accumulator, sticky flag and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      acc          <= '0;
      p_reg        <= '0;
      p_valid      <= 1'b0;
      sticky       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_reg <= prod_sat;
        count <= count + 3'd1;
      end
      // Handshake only happens in DONE, where no term or product is in flight
      if (handshake) begin
        acc          <= '0;
        sticky       <= 1'b0;
        out_valid_q  <= 1'b0;
        out_result_q <= '0;
        out_ovf_q    <= 1'b0;
      end else begin
        if (p_valid) acc <= sum_sat;
        if ((accept && prod_ovf) || (p_valid && sum_ovf)) sticky <= 1'b1;
        if (state_q == DONE) begin
          out_valid_q  <= 1'b1;
          out_result_q <= acc;
          out_ovf_q    <= sticky;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a result scoreboard and an
// independent integer reference model of the saturating dot product.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mac_accumulator_if bus();

  mac_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ta[8];
  logic [7:0] tb_[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact floor division by 64, clamp, accumulate with clamp
  function automatic exp_t model();
    exp_t r;
    int   acc;
    int   p;
    int   q;
    bit   ovf;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = $signed(ta[i]) * $signed(tb_[i]);
      if (p >= 0) q = p / 64;
      else        q = -((-p + 63) / 64);
      if (q > 127)  begin q = 127;  ovf = 1'b1; end
      if (q < -128) begin q = -128; ovf = 1'b1; end
      acc = acc + q;
      if (acc > 127)  begin acc = 127;  ovf = 1'b1; end
      if (acc < -128) begin acc = -128; ovf = 1'b1; end
    end
    r.res = acc[7:0];
    r.ovf = ovf;
    return r;
  endfunction

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      ta[i]  = a;
      tb_[i] = b;
    end
  endtask

  task automatic send_batch(input bit gaps);
    int w;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.in_valid = 1'b0;
          bus.in_a     = 8'($urandom);
          bus.in_b     = 8'($urandom);
          tick();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_a     = ta[i];
      bus.in_b     = tb_[i];
      w = 0;
      while (!bus.in_ready && w < 50) begin
        tick();
        w++;
      end
      check("in_ready_wait", {7'b0, bus.in_ready}, 8'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    sb.push_back(model());
  endtask

  task automatic collect(input string tag, input int hold);
    int   lat;
    exp_t e;
    logic [7:0] r0;
    logic       o0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat[7:0], 8'd2);
    e = sb.pop_front();
    check({tag, "_result"}, bus.out_result, e.res);
    check({tag, "_ovf"}, {7'b0, bus.out_overflow}, {7'b0, e.ovf});
    r0 = bus.out_result;
    o0 = bus.out_overflow;
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, {7'b0, bus.out_valid}, 8'd1);
      check({tag, "_hold_result"}, bus.out_result, r0);
      check({tag, "_hold_ovf"}, {7'b0, bus.out_overflow}, {7'b0, o0});
      check({tag, "_hold_in_ready"}, {7'b0, bus.in_ready}, 8'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, {7'b0, bus.out_valid}, 8'd0);
    check({tag, "_post_in_ready"}, {7'b0, bus.in_ready}, 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", {7'b0, bus.out_valid}, 8'd0);
    check("rst_out_result", bus.out_result, 8'h00);
    check("rst_out_ovf", {7'b0, bus.out_overflow}, 8'd0);
    check("rst_in_ready", {7'b0, bus.in_ready}, 8'd0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", {7'b0, bus.in_ready}, 8'd1);

    fill(8'h10, 8'h20); send_batch(1'b0); collect("nominal", 0);
    fill(8'h40, 8'h40); send_batch(1'b0); collect("sat_pos_bp", 5);
    fill(8'h10, 8'h20); send_batch(1'b0); collect("after_bp", 0);
    fill(8'h80, 8'h40); send_batch(1'b0); collect("sat_neg", 0);
    fill(8'h00, 8'h00); ta[0] = 8'h80; tb_[0] = 8'h80;
    send_batch(1'b0); collect("prod_sat", 2);
    fill(8'hFF, 8'h01); send_batch(1'b0); collect("floor_neg", 0);
    fill(8'h01, 8'h01); send_batch(1'b0); collect("floor_pos", 0);

    // Three accepted terms, then reset with the third product still in flight
    fill(8'h40, 8'h40);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = ta[i];
      bus.in_b     = tb_[i];
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {7'b0, bus.out_valid}, 8'd0);
    check("midrst_in_ready", {7'b0, bus.in_ready}, 8'd1);
    fill(8'h10, 8'h20); send_batch(1'b0); collect("midrst_batch", 0);

    fill(8'h10, 8'h20); send_batch(1'b1); collect("gapped", 0);

    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) begin
        ta[i]  = 8'($urandom);
        tb_[i] = 8'($urandom);
      end
      send_batch(1'b1);
      collect("random", 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
